// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one valid/ready command in, one AXI read or write out, one response back.
// Optional watchdog enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axil_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  input  logic        cmd_insn,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_write,
  output logic        timeout,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, RSP} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        write_q, insn_q;
  logic        aw_done, w_done;
  logic        cmd_fire, aw_fire, w_fire;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign aw_fire  = mem_axi_awvalid && mem_axi_awready;
  assign w_fire   = mem_axi_wvalid && mem_axi_wready;

  assign mem_axi_awaddr = addr_q;
  assign mem_axi_awprot = '0;
  assign mem_axi_wdata  = wdata_q;
  assign mem_axi_wstrb  = wstrb_q;
  assign mem_axi_araddr = addr_q;
  assign mem_axi_arprot = {insn_q, 2'b00};
  assign rsp_write      = write_q;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire) state_nxt = cmd_write ? WREQ : RADDR;
      RADDR:   if (mem_axi_arready) state_nxt = RDATA;
      RDATA:   if (mem_axi_rvalid) state_nxt = RSP;
      // AW and W complete independently; leave once both have been accepted
      WREQ:    if ((aw_done || aw_fire) && (w_done || w_fire)) state_nxt = WRESP;
      WRESP:   if (mem_axi_bvalid) state_nxt = RSP;
      RSP:     if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready       = 1'b0;
    mem_axi_arvalid = 1'b0;
    mem_axi_rready  = 1'b0;
    mem_axi_awvalid = 1'b0;
    mem_axi_wvalid  = 1'b0;
    mem_axi_bready  = 1'b0;
    rsp_valid       = 1'b0;
    case (state)
      IDLE:  cmd_ready = resetn;
      RADDR: mem_axi_arvalid = 1'b1;
      RDATA: mem_axi_rready = 1'b1;
      WREQ: begin
        mem_axi_awvalid = !aw_done;
        mem_axi_wvalid  = !w_done;
      end
      WRESP: mem_axi_bready = 1'b1;
      RSP:   rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      insn_q    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (cmd_fire) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        write_q <= cmd_write;
        insn_q  <= cmd_insn;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
      if (state == RDATA && mem_axi_rvalid) rsp_rdata <= mem_axi_rdata;
      if (state == WRESP && mem_axi_bvalid) rsp_rdata <= '0;
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        timeout_q;

  // Flag only; AXI gives no way to abandon a started transaction, so the FSM keeps waiting
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (cmd_fire) begin
      wd_cnt <= '0;
    end else if (state != IDLE && state != RSP) begin
      if (!timeout_q) wd_cnt <= wd_cnt + 32'd1;
      if (wd_cnt + 32'd1 >= TIMEOUT_CYCLES) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  // Watchdog limit is meaningless without the counter
  assign timeout = (TIMEOUT_CYCLES == 32'd0) && 1'b0;
`endif

endmodule
